// File: rtl/ieee_754_divider.sv
// Sequential IEEE 754 single-precision divider: restoring mantissa division, one quotient bit per clock, RNE rounding.
// Define FP_DIV_SPECIAL_EN to enable NaN/Inf/denormal handling and exponent over/underflow saturation.
`timescale 1ns/1ps
module ieee_754_divider #(
  parameter int WIDTH    = 24,
  parameter int QBITS    = 26,
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        start,
  output logic [31:0] result,
  output logic        valid,
  output logic        busy
);

  localparam int CW = $clog2(QBITS);
  localparam logic [1:0] IDLE = 2'd0, ITER = 2'd1, NORM = 2'd2;

  logic [1:0]       state;
  logic             sign;
  logic [9:0]       exponent;
  logic [WIDTH:0]   remainder;
  logic [WIDTH-1:0] divisor;
  logic [QBITS-1:0] quotient;
  logic [CW-1:0]    count;
  logic             zero_case;
  logic [31:0]      zero_result;

  logic             op_sign;
  logic [9:0]       op_exp;
  logic             op_special;
  logic [31:0]      op_special_result;

`ifdef FP_DIV_SPECIAL_EN
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  assign a_nan  = (rs1[30:23] == 8'hFF) && (rs1[22:0] != 23'd0);
  assign b_nan  = (rs2[30:23] == 8'hFF) && (rs2[22:0] != 23'd0);
  assign a_inf  = (rs1[30:23] == 8'hFF) && (rs1[22:0] == 23'd0);
  assign b_inf  = (rs2[30:23] == 8'hFF) && (rs2[22:0] == 23'd0);
  // A zero exponent field covers both true zero and denormals, which are flushed.
  assign a_zero = (rs1[30:23] == 8'h00);
  assign b_zero = (rs2[30:23] == 8'h00);
`endif

  // Operand decode used on the accepting edge.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    op_sign           = rs1[31] ^ rs2[31];
    op_exp            = {2'b00, rs1[30:23]} - {2'b00, rs2[30:23]} + 10'(EXP_BIAS);
    op_special        = 1'b0;
    op_special_result = 32'h0;
`ifdef FP_DIV_SPECIAL_EN
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      op_special        = 1'b1;
      op_special_result = 32'h7FC0_0000;
    end else if (a_inf || b_zero) begin
      op_special        = 1'b1;
      op_special_result = {op_sign, 8'hFF, 23'd0};
    end else if (b_inf || a_zero) begin
      op_special        = 1'b1;
      op_special_result = {op_sign, 31'd0};
    end
`else
    if (rs1[30:0] == 31'd0) begin
      op_special        = 1'b1;
      op_special_result = {op_sign, 31'd0};
    end else if (rs2[30:0] == 31'd0) begin
      op_special        = 1'b1;
      op_special_result = {op_sign, 8'hFF, 23'd0};
    end
`endif
  end

  // One restoring step: the remainder always stays below twice the divisor.
  logic           q_bit;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] next_rem;
  assign q_bit    = remainder >= {1'b0, divisor};
  assign diff     = remainder - {1'b0, divisor};
  assign next_rem = (q_bit ? diff : remainder) << 1;

  logic [WIDTH-2:0] mant;
  logic             guard, sticky, round_up;
  logic [9:0]       exp_adj;
  logic [31:0]      norm_result;
`ifdef FP_DIV_SPECIAL_EN
  logic [32:0]      ext;
`endif

  always_comb begin
    if (quotient[QBITS-1]) begin
      mant    = quotient[QBITS-2:2];
      guard   = quotient[1];
      sticky  = quotient[0] | (remainder != '0);
      exp_adj = exponent;
    end else begin
      mant    = quotient[QBITS-3:1];
      guard   = quotient[0];
      sticky  = (remainder != '0);
      exp_adj = exponent - 10'd1;
    end
    round_up = guard & (sticky | mant[0]);
`ifdef FP_DIV_SPECIAL_EN
    // Round on the full 10-bit exponent so a mantissa carry is seen by the range checks.
    ext = {exp_adj, mant} + 33'(round_up);
    if ($signed(ext[32:23]) >= 10'sd255)
      norm_result = {sign, 8'hFF, 23'd0};
    else if ($signed(ext[32:23]) <= 10'sd0)
      norm_result = {sign, 31'd0};
    else
      norm_result = {sign, ext[30:0]};
`else
    norm_result = {sign, 31'({exp_adj, mant} + 33'(round_up))};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sign        <= 1'b0;
      exponent    <= '0;
      remainder   <= '0;
      divisor     <= '0;
      quotient    <= '0;
      count       <= '0;
      zero_case   <= 1'b0;
      zero_result <= '0;
      result      <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sign        <= op_sign;
          exponent    <= op_exp;
          remainder   <= {2'b01, rs1[22:0]};
          divisor     <= {1'b1, rs2[22:0]};
          quotient    <= '0;
          count       <= '0;
          zero_case   <= op_special;
          zero_result <= op_special_result;
          busy        <= 1'b1;
          state       <= op_special ? NORM : ITER;
        end
        ITER: begin
          remainder <= next_rem;
          quotient  <= {quotient[QBITS-2:0], q_bit};
          count     <= count + 1'b1;
          if (count == CW'(QBITS - 1)) state <= NORM;
        end
        NORM: begin
          result <= zero_case ? zero_result : norm_result;
          valid  <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
